reg8bit_serial_tx: RTL and testbench

Parallel-to-serial readout for 8-bit register values: takes one byte over a valid/ready handshake and shifts it out on a single line as an asynchronous serial frame (start bit, 8 data bits LSB first, optional parity, stop bit). It is the unload counterpart to the 8-bit load register. It sits between a register's `data_Out` and an external serial pin for debug and readback.

---
 rtl/reg8bit_serial_pkg.sv | 18 +
 rtl/reg8bit_serial_tx_baud.sv | 30 +++
 rtl/reg8bit_serial_tx.sv | 123 ++++++++++++
 tb/tb_reg8bit_serial_tx.sv | 142 ++++++++++++++
 4 files changed

// File: rtl/reg8bit_serial_pkg.sv
// Shared types and constants for the 8-bit serial readout transmitter.
// Parity support is controlled by REG8BIT_SERIAL_TX_PARITY_EN in the top module.
package reg8bit_serial_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_e;

  localparam int         DATA_BITS = 8;
  localparam logic       TX_IDLE   = 1'b1;
  localparam logic       TX_START  = 1'b0;
  localparam logic [2:0] LAST_BIT  = 3'(DATA_BITS - 1);

endpackage

// File: rtl/reg8bit_serial_tx_baud.sv
// Bit-period timer for reg8bit_serial_tx: counts 0..CLKS_PER_BIT-1 and flags
// the last cycle of each bit period with a one-cycle tick.
module baud_tick_gen #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic res,
  input  logic clr_i,
  output logic tick_o
);

  localparam int            CW   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick_o = (cnt_q == LAST);

  // Reload at every bit boundary so each bit lasts exactly CLKS_PER_BIT cycles.
  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (clr_i || tick_o) cnt_d = '0;
  end

  always_ff @(posedge clk or negedge res) begin
    if (!res) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

endmodule

// File: rtl/reg8bit_serial_tx.sv
// Parallel-to-serial readout: start bit, 8 data bits LSB first, optional even
// parity (REG8BIT_SERIAL_TX_PARITY_EN), stop bit. All outputs are registered.
//
// state  | meaning
// IDLE   | line high, rdy=1, waiting for en
// START  | start bit (line low)
// DATA   | shifting out 8 data bits, LSB first
// PARITY | even parity bit of the captured byte (parity build only)
// STOP   | stop bit (line high), returns to IDLE
module reg8bit_serial_tx
  import reg8bit_serial_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       res,
  input  logic [7:0] data_In,
  input  logic       en,
  output logic       rdy,
  output logic       tx,
  output logic       busy
);

  state_e     state_q;
  logic [7:0] shift_q;
  logic [2:0] bit_cnt_q;
  logic       tx_q;
  logic       rdy_q;
  logic       busy_q;
  logic       tick;
`ifdef REG8BIT_SERIAL_TX_PARITY_EN
  logic       parity_q;
`endif

  baud_tick_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk   (clk),
    .res   (res),
    .clr_i (state_q == IDLE),
    .tick_o(tick)
  );

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      tx_q      <= TX_IDLE;
      rdy_q     <= 1'b1;
      busy_q    <= 1'b0;
`ifdef REG8BIT_SERIAL_TX_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        IDLE: begin
          // rdy_q is high throughout IDLE, so en alone qualifies the load.
          if (en) begin
            shift_q  <= data_In;
`ifdef REG8BIT_SERIAL_TX_PARITY_EN
            parity_q <= ^data_In;
`endif
            state_q  <= START;
            tx_q     <= TX_START;
            rdy_q    <= 1'b0;
            busy_q   <= 1'b1;
          end
        end
        START: begin
          if (tick) begin
            state_q <= DATA;
            tx_q    <= shift_q[0];
          end
        end
        DATA: begin
          if (tick) begin
            shift_q   <= {1'b0, shift_q[7:1]};
            bit_cnt_q <= bit_cnt_q + 3'd1;
            if (bit_cnt_q == LAST_BIT) begin
`ifdef REG8BIT_SERIAL_TX_PARITY_EN
              state_q <= PARITY;
              tx_q    <= parity_q;
`else
              state_q <= STOP;
              tx_q    <= TX_IDLE;
`endif
            end else begin
              tx_q <= shift_q[1];
            end
          end
        end
`ifdef REG8BIT_SERIAL_TX_PARITY_EN
        PARITY: begin
          if (tick) begin
            state_q <= STOP;
            tx_q    <= TX_IDLE;
          end
        end
`endif
        STOP: begin
          if (tick) begin
            state_q <= IDLE;
            tx_q    <= TX_IDLE;
            rdy_q   <= 1'b1;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          tx_q    <= TX_IDLE;
          rdy_q   <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign tx   = tx_q;
  assign rdy  = rdy_q;
  assign busy = busy_q;

endmodule

// File: tb/tb_reg8bit_serial_tx.sv
// Self-checking bench for reg8bit_serial_tx against a frame-level reference model.
// Build with REG8BIT_SERIAL_TX_PARITY_EN defined to exercise the parity variant.
module tb_reg8bit_serial_tx;

  localparam int CPB = 4;
`ifdef REG8BIT_SERIAL_TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  localparam int FL = NBITS * CPB;

  logic       clk = 1'b0;
  logic       res = 1'b0;
  logic       en  = 1'b0;
  logic [7:0] data_In = 8'h00;
  logic       rdy, tx, busy;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  reg8bit_serial_tx #(.CLKS_PER_BIT(CPB)) dut (
    .clk    (clk),
    .res    (res),
    .data_In(data_In),
    .en     (en),
    .rdy    (rdy),
    .tx     (tx),
    .busy   (busy)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", tag, got, want);
    end
  endtask

  // Line level of frame bit idx: start, 8 data bits LSB first, [even parity], stop.
  function automatic logic exp_bit(input logic [7:0] d, input int idx);
    if (idx == 0) return 1'b0;
    if (idx <= 8) return d[idx-1];
    if (idx == 9 && NBITS == 11) return (($countones(d) % 2) == 1);
    return 1'b1;
  endfunction

  task automatic check_idle(input string tag);
    check_val({tag, "_tx"},   tx,   1);
    check_val({tag, "_rdy"},  rdy,  1);
    check_val({tag, "_busy"}, busy, 0);
  endtask

  // Called at a negedge with the DUT idle; ends on the negedge of the idle cycle after the frame.
  task automatic run_frame(input logic [7:0] d, input bit disturb, input bit hold);
    int low;
    low = 0;
    data_In = d;
    en = 1'b1;
    @(posedge clk); #1;
    if (!hold) en = 1'b0;
    for (int k = 0; k < FL; k++) begin
      @(negedge clk);
      check_val($sformatf("tx_%02h_c%0d", d, k), tx, exp_bit(d, k / CPB));
      if (!rdy && busy) low++;
      if (disturb) begin
        data_In = 8'($urandom);
        en = (k < FL - 1) ? 1'($urandom_range(0, 1)) : 1'b0;
      end
    end
    check_val("rdy_low_cycles", low, FL);
    @(negedge clk);
    check_idle("after_frame");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    // Held in reset with en high: nothing may start.
    en = 1'b1;
    data_In = 8'h55;
    repeat (3) begin
      @(negedge clk);
      check_idle("in_reset");
    end
    // Release together with en: load is taken on the first edge with res=1.
    res = 1'b1;
    run_frame(8'h69, 1'b0, 1'b0);

    // Data stability: changes to data_In and en pulses during the frame are ignored.
    run_frame(8'h69, 1'b1, 1'b0);
    @(negedge clk);
    check_idle("no_second_frame");

    // Back-to-back with en held: exactly one idle cycle between frames.
    run_frame(8'hF8, 1'b0, 1'b1);
    run_frame(8'hF8, 1'b0, 1'b1);
    run_frame(8'hF8, 1'b0, 1'b0);

    // Mid-frame reset during data bit 3.
    data_In = 8'h69;
    en = 1'b1;
    @(posedge clk); #1;
    en = 1'b0;
    for (int k = 0; k < 18; k++) begin
      @(negedge clk);
      check_val($sformatf("pre_rst_c%0d", k), tx, exp_bit(8'h69, k / CPB));
    end
    #1;
    res = 1'b0;
    en = 1'b1;
    #1;
    check_idle("async_rst");
    repeat (3) begin
      @(negedge clk);
      check_idle("rst_hold");
    end
    res = 1'b1;
    run_frame(8'h69, 1'b0, 1'b0);

    // Randomised frames with random idle gaps and random disturbance.
    repeat (8) begin
      int gap;
      gap = $urandom_range(0, 3);
      for (int g = 0; g < gap; g++) begin
        @(negedge clk);
        check_idle("gap");
      end
      run_frame(8'($urandom), 1'($urandom_range(0, 1)), 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
